// File: rtl/hamming_pack.sv
// Shared types and constants for the SECDED Hamming(16,11) decoder slice.
package hamming_pack;

    localparam int unsigned CW_W   = 16;
    localparam int unsigned DATA_W = 11;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CORR = 2'b01,
        ERR_DBL  = 2'b10
    } err_t;

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_SECOND,
        ST_CALC,
        ST_OUT
    } dec_state_t;

    // Codeword positions of b1..b11; the remaining positions hold parity.
    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            d[k] = cw[DATA_POS[k]];
        end
        return d;
    endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational Hamming(16,11) syndrome, overall parity and single-bit fix.
module ham_syndrome
    import hamming_pack::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [3:0]      syn,
    output logic            par,
    output logic [CW_W-1:0] fixed
);

    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i < CW_W; i++) begin
            if (cw[i]) begin
                syn = syn ^ i[3:0];
            end
        end
        par   = ^cw;
        fixed = cw ^ (CW_W'(1) << syn);
    end

endmodule

// File: rtl/ham_dec.sv
// Byte-stream SECDED Hamming(16,11) decoder with valid/ready on both sides.
// Optional saturating error counters under HAM_DEC_STATS_EN.
module ham_dec
    import hamming_pack::*;
#(
    parameter bit LO_FIRST = 1'b1
`ifdef HAM_DEC_STATS_EN
    , parameter int unsigned STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_err,
    output logic [3:0]        out_pos
`ifdef HAM_DEC_STATS_EN
    , input  logic              stat_clr,
    output logic [STAT_W-1:0] cnt_corr,
    output logic [STAT_W-1:0] cnt_uncorr
`endif
);

    dec_state_t        state, state_d;
    logic [7:0]        first_q, second_q;
    logic              ready_q, valid_q;
    logic              in_hs, out_hs;
    logic              take_first, take_second, clr_bytes, load_out;
    logic [CW_W-1:0]   cw, fixed;
    logic [3:0]        syn;
    logic              par;
    err_t              res_err;
    logic [DATA_W-1:0] res_data;
    logic              unused_par;

    assign in_hs     = in_valid & ready_q;
    assign out_hs    = valid_q & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = valid_q;

    assign cw = LO_FIRST ? {second_q, first_q} : {first_q, second_q};

    ham_syndrome u_syn (
        .cw    (cw),
        .syn   (syn),
        .par   (par),
        .fixed (fixed)
    );

    assign unused_par = ^{fixed[0], fixed[1], fixed[2], fixed[4], fixed[8]};

    always_comb begin
        res_err  = ERR_NONE;
        res_data = extract_data(cw);
        if (par) begin
            res_err  = ERR_CORR;
            res_data = extract_data(fixed);
        end else if (syn != '0) begin
            res_err = ERR_DBL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FIRST;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d == ST_FIRST) || (state_d == ST_SECOND);
            valid_q <= (state_d == ST_OUT);
        end
    end

    // sync outranks a simultaneous byte handshake while collecting bytes.
    always_comb begin
        state_d     = state;
        take_first  = 1'b0;
        take_second = 1'b0;
        clr_bytes   = 1'b0;
        load_out    = 1'b0;
        case (state)
            ST_FIRST: begin
                if (sync) begin
                    clr_bytes = 1'b1;
                end else if (in_hs) begin
                    take_first = 1'b1;
                    state_d    = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (sync) begin
                    clr_bytes = 1'b1;
                    state_d   = ST_FIRST;
                end else if (in_hs) begin
                    take_second = 1'b1;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                load_out = 1'b1;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (out_hs) begin
                    state_d = ST_FIRST;
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= '0;
            second_q <= '0;
        end else if (clr_bytes) begin
            first_q  <= '0;
            second_q <= '0;
        end else begin
            if (take_first) begin
                first_q <= in_byte;
            end
            if (take_second) begin
                second_q <= in_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_err  <= ERR_NONE;
            out_pos  <= '0;
        end else if (load_out) begin
            out_data <= res_data;
            out_err  <= res_err;
            out_pos  <= syn;
        end
    end

`ifdef HAM_DEC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (stat_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_hs) begin
            if ((out_err == ERR_CORR) && (cnt_corr != '1)) begin
                cnt_corr <= cnt_corr + STAT_W'(1);
            end
            if ((out_err == ERR_DBL) && (cnt_uncorr != '1)) begin
                cnt_uncorr <= cnt_uncorr + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ham_dec.sv
// Self-checking bench for ham_dec: vector table plus corner-case sequences.
module tb_ham_dec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic        in_valid;
    logic        in_ready, in_ready0;
    logic [7:0]  in_byte;
    logic        out_valid, out_valid0;
    logic        out_ready;
    logic [10:0] out_data, out_data0;
    logic [1:0]  out_err, out_err0;
    logic [3:0]  out_pos, out_pos0;
`ifdef HAM_DEC_STATS_EN
    logic        stat_clr;
    logic [15:0] cnt_corr, cnt_uncorr, cnt_corr0, cnt_uncorr0;
    int          exp_corr, exp_uncorr;
`endif

    always #5 clk = ~clk;

    ham_dec #(.LO_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .out_pos(out_pos)
`ifdef HAM_DEC_STATS_EN
        , .stat_clr(stat_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
`endif
    );

    ham_dec #(.LO_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid), .in_ready(in_ready0),
        .in_byte(in_byte), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_err(out_err0), .out_pos(out_pos0)
`ifdef HAM_DEC_STATS_EN
        , .stat_clr(stat_clr), .cnt_corr(cnt_corr0), .cnt_uncorr(cnt_uncorr0)
`endif
    );

    typedef struct {
        logic [10:0] d;
        logic [1:0]  e;
        logic [3:0]  p;
    } res_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        res_t       r;
    } vec_t;

    res_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input bit use0);
        int   n;
        res_t exp;
        logic v;
        n = 0;
        out_ready = 1'b1;
        v = use0 ? out_valid0 : out_valid;
        while (!v && n < 20) begin
            @(posedge clk); #1;
            n++;
            v = use0 ? out_valid0 : out_valid;
        end
        if (!v) begin
            check("out_valid timeout", 32'(v), 32'd1);
        end else if (sbq.size() == 0) begin
            check("unexpected output", 32'(sbq.size()), 32'd1);
        end else begin
            exp = sbq.pop_front();
            check("out_data", 32'(use0 ? out_data0 : out_data), 32'(exp.d));
            check("out_err",  32'(use0 ? out_err0  : out_err),  32'(exp.e));
            check("out_pos",  32'(use0 ? out_pos0  : out_pos),  32'(exp.p));
`ifdef HAM_DEC_STATS_EN
            if (!use0) begin
                if (exp.e == 2'b01) exp_corr++;
                if (exp.e == 2'b10) exp_uncorr++;
            end
`endif
            @(posedge clk); #1;
`ifdef HAM_DEC_STATS_EN
            if (!use0) begin
                check("cnt_corr", 32'(cnt_corr), 32'(exp_corr));
                check("cnt_uncorr", 32'(cnt_uncorr), 32'(exp_uncorr));
            end
`endif
        end
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];
    res_t held;

    initial begin
        vecs[0] = '{8'h00, 8'h00, '{11'h000, 2'b00, 4'd0}};
        vecs[1] = '{8'hFF, 8'hFF, '{11'h7FF, 2'b00, 4'd0}};
        vecs[2] = '{8'hDF, 8'hFF, '{11'h7FF, 2'b01, 4'd5}};
        vecs[3] = '{8'hFE, 8'hFF, '{11'h7FF, 2'b01, 4'd0}};
        vecs[4] = '{8'hD7, 8'hFF, '{11'h7FC, 2'b10, 4'd6}};
        vecs[5] = '{8'h0F, 8'h00, '{11'h001, 2'b00, 4'd0}};
        vecs[6] = '{8'h0F, 8'h80, '{11'h001, 2'b01, 4'd15}};
        vecs[7] = '{8'h0D, 8'h80, '{11'h401, 2'b10, 4'd14}};

        rst_n = 1'b0; sync = 1'b0; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
`ifdef HAM_DEC_STATS_EN
        stat_clr = 1'b0; exp_corr = 0; exp_uncorr = 0;
`endif
        #12;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_err", 32'(out_err), 32'd0);
        check("reset out_pos", 32'(out_pos), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            sbq.push_back(vecs[i].r);
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            check("out_valid low in calc", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check("out_valid one edge later", 32'(out_valid), 32'd1);
            get_result(1'b0);
        end

        // Backpressure: result held, new bytes refused.
        held = '{11'h001, 2'b00, 4'd0};
        sbq.push_back(held);
        send_byte(8'h0F);
        send_byte(8'h00);
        @(posedge clk); #1;
        in_valid = 1'b1; in_byte = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall out_data", 32'(out_data), 32'(held.d));
            check("stall out_err", 32'(out_err), 32'(held.e));
        end
        in_valid = 1'b0;
        get_result(1'b0);
        sbq.push_back('{11'h7FF, 2'b00, 4'd0});
        send_byte(8'hFF);
        send_byte(8'hFF);
        get_result(1'b0);

        // sync discards 0xAA and blocks 0x12.
        send_byte(8'hAA);
        sync = 1'b1; in_valid = 1'b1; in_byte = 8'h12;
        @(posedge clk); #1;
        sync = 1'b0; in_valid = 1'b0;
        check("in_ready after sync", 32'(in_ready), 32'd1);
        sbq.push_back('{11'h7FF, 2'b00, 4'd0});
        send_byte(8'hFF);
        send_byte(8'hFF);
        get_result(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("no extra output", 32'(out_valid), 32'd0);

        // Reset while in CALC, previous result nonzero.
        send_byte(8'hDF);
        send_byte(8'hFF);
        rst_n = 1'b0;
        #1;
        check("rst calc out_valid", 32'(out_valid), 32'd0);
        check("rst calc out_data", 32'(out_data), 32'd0);
        check("rst calc out_err", 32'(out_err), 32'd0);
        check("rst calc out_pos", 32'(out_pos), 32'd0);
        check("rst calc in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst held out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after rst", 32'(in_ready), 32'd1);
`ifdef HAM_DEC_STATS_EN
        exp_corr = 0; exp_uncorr = 0;
`endif
        sbq.push_back('{11'h001, 2'b01, 4'd15});
        send_byte(8'h0F);
        send_byte(8'h80);
        get_result(1'b0);

        // High byte first on the LO_FIRST=0 instance.
        sbq.push_back('{11'h7FF, 2'b01, 4'd5});
        send_byte(8'hFF);
        send_byte(8'hDF);
        get_result(1'b1);

`ifdef HAM_DEC_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr corr", 32'(cnt_corr), 32'd0);
        check("stat_clr uncorr", 32'(cnt_uncorr), 32'd0);
`endif
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ham_dec.md
Name: ham_dec

Overview:
- Hardware SECDED Hamming(16,11) decoder; the receive-side counterpart of the program-1 software encoder.
- Accepts a codeword as two bytes over a byte-wide valid/ready input.
- Computes the 4-bit syndrome and overall parity, corrects any single-bit error and flags double-bit errors.
- Presents the 11-bit data word plus status on a valid/ready output. Sits between data-memory readback and the consumer of the decoded words.

Parameters:
LO_FIRST, 1, 1: low byte {b4,b3,b2,p4,b1,p2,p1,p0} arrives first; 0: high byte {b11..b5,p8} first
STAT_W, 16, width of the saturating error counters (only with HAM_DEC_STATS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
sync  in  1  abandon any partially received codeword; next byte is treated as first
in_valid  in  1  in_byte valid
in_ready  out  1  block can accept a byte
in_byte  in  8  codeword byte
out_valid  out  1  decoded result valid
out_ready  in  1  consumer accepts result
out_data  out  11  {b11..b1}; b1 at bit 0
out_err  out  2  00 clean, 01 single corrected, 10 double detected, 11 never driven
out_pos  out  4  syndrome: flipped bit position (0 = p0 or none)

Behaviour:
- Codeword bit i = Hamming position i: 0=p0, 1=p1, 2=p2, 3=b1, 4=p4, 5..7=b2..b4, 8=p8, 9..15=b5..b11. Low byte = bits 7:0.
- Syndrome S = XOR of indices i (1..15) where bit i = 1. P = XOR of all 16 bits.
- Classification:
  - S=0, P=0: err 00.
  - P=1: err 01. Flip bit S; when S=0 only p0 is wrong and data is unchanged.
  - S≠0, P=0: err 10. Data is passed uncorrected.
- FSM states: FIRST, SECOND, CALC, OUT.
  - FIRST: in_ready=1. A handshake latches the byte and moves to SECOND.
  - SECOND: in_ready=1. A handshake latches the byte and moves to CALC.
  - CALC: in_ready=0, out_valid=0. Lasts 1 cycle; the result registers load and the FSM moves to OUT.
  - OUT: out_valid=1, outputs held stable until out_ready=1, then the FSM moves to FIRST.
- Latency: second byte accepted on edge k → out_valid=1 from edge k+1. Maximum throughput is 1 word per 4 cycles.
- in_ready and out_valid are registered (state-decoded) with no combinational path from in_valid or out_ready.
- sync:
  - Acts in FIRST and SECOND only: forces FIRST, discards any latched byte, and blocks any simultaneous byte handshake.
  - Ignored in CALC and OUT.
- A byte offered during CALC or OUT is not accepted because in_ready=0.
- Reset (async, any time including mid-word):
  - state=FIRST, byte registers=0, in_ready=0 while rst_n=0 and 1 on the first cycle after release.
  - out_valid=0, out_data=0, out_err=00, out_pos=0.
- out_data, out_err and out_pos do not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro HAM_DEC_STATS_EN.
- When defined:
  - Extra outputs cnt_corr[STAT_W] and cnt_uncorr[STAT_W].
  - Each increments by 1 on the out handshake of an err 01 / err 10 result, saturating at all-ones.
  - Both clear on reset and on stat_clr (new input, 1 bit). stat_clr wins over a simultaneous increment.
- When undefined: the ports, registers and stat_clr are absent; all other behaviour is identical.

Decomposition:
- Package hamming_pack:
  - err_t enum {ERR_NONE=2'b00, ERR_CORR=2'b01, ERR_DBL=2'b10}
  - dec_state_t enum
  - localparams CW_W=16, DATA_W=11
  - data-position list {3,5,6,7,9..15}
- Sub-module ham_syndrome: purely combinational, 16-bit codeword in → S[3:0], P, corrected codeword out. Reusable by a future hardware encoder check.

Test Plan:
- Bytes 0x00, 0x00 → out_data 0x000, err 00, pos 0. Bytes 0xFF, 0xFF → out_data 0x7FF, err 00; out_valid rises exactly 1 edge after the second byte.
- Bytes 0xDF, 0xFF (bit 5 flipped) → out_data 0x7FF, err 01, pos 5. Bytes 0xFE, 0xFF (p0 flipped) → 0x7FF, err 01, pos 0.
- Bytes 0xD7, 0xFF (bits 3,5 flipped) → out_data 0x7FC, err 10, pos 6. With HAM_DEC_STATS_EN, cnt_uncorr=1 after the handshake.
- Hold out_ready=0 for 5 cycles while in_valid=1 with bytes offered → in_ready=0 and outputs stable; out_ready=1 → accepted; the next word then decodes correctly.
- Send byte 0xAA, then sync=1 together with in_valid=1 (byte 0x12), then bytes 0xFF, 0xFF → 0x12 rejected, only 0x7FF/err 00 emitted. Deassert rst_n in CALC → out_valid=0 immediately and all outputs 0; state FIRST after release.
- LO_FIRST=0: bytes 0xFF (high), 0xDF (low) → 0x7FF, err 01, pos 5.
